// File: rtl/debounce_scheduler.sv
// debounce_scheduler: multi-channel button debouncer with a shared sample tick,
// per-channel pending event slots and a round-robin valid/ready event port.
module debounce_scheduler #(
   parameter int N_CH         = 4,
   parameter int TICK_DIV     = 25000,
   parameter int STABLE_TICKS = 3
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [N_CH-1:0]         btn_in_i,
   output logic [N_CH-1:0]         btn_level_o,
   output logic                    evt_valid_o,
   input  logic                    evt_ready_i,
   output logic [$clog2(N_CH)-1:0] evt_chan_o,
   output logic                    evt_rise_o,
   output logic                    evt_drop_o,
   input  logic                    drop_clr_i
);

   localparam int CHW = $clog2(N_CH);
   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW  = $clog2(STABLE_TICKS + 1);
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0]  STAB_LAST = SW'(STABLE_TICKS - 1);
   localparam logic [CHW-1:0] CHAN_LAST = CHW'(N_CH - 1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PRESENT = 1'b1
   } state_t;

   logic [N_CH-1:0] sync1_q;
   logic [N_CH-1:0] sync2_q;
   logic [TW-1:0]   tick_cnt_q;
   logic [TW-1:0]   tick_cnt_d;
   logic            tick;
   logic [N_CH-1:0] post;

   state_t          state_q, state_d;
   logic [N_CH-1:0] pend_q, pend_d;
   logic [N_CH-1:0] pol_q, pol_d;
   logic [CHW-1:0]  chan_q, chan_d;
   logic            rise_q, rise_d;
   logic            valid_q, valid_d;
   logic [CHW-1:0]  rr_q, rr_d;
   logic            drop_q, drop_d;
   logic [N_CH-1:0] clr_mask;
   logic            drop_set;
   logic            found;
   logic [CHW-1:0]  pick;

   // Two-flop synchronizer for the raw pad inputs.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_in_i;
         sync2_q <= sync1_q;
      end
   end

   // Shared sample-tick divider; tick marks the last count before wrap.
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   // Divider count register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) tick_cnt_q <= '0;
      else         tick_cnt_q <= tick_cnt_d;
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
         logic [SW-1:0] stab_cnt_q, stab_cnt_d;
         logic          level_q, level_d;
         logic          post_c;

         // Stable-count qualifier: a differing level must be seen on STABLE_TICKS ticks in a row.
         always_comb begin
            stab_cnt_d = stab_cnt_q;
            level_d    = level_q;
            post_c     = 1'b0;
            if (tick) begin
               if (sync2_q[gi] == level_q) begin
                  stab_cnt_d = '0;
               end else if (stab_cnt_q == STAB_LAST) begin
                  level_d    = sync2_q[gi];
                  stab_cnt_d = '0;
                  post_c     = 1'b1;
               end else begin
                  stab_cnt_d = stab_cnt_q + SW'(1);
               end
            end
         end

         // Qualifier state registers.
         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
               stab_cnt_q <= '0;
               level_q    <= 1'b0;
            end else begin
               stab_cnt_q <= stab_cnt_d;
               level_q    <= level_d;
            end
         end

         assign btn_level_o[gi] = level_q;
         assign post[gi]        = post_c;
      end
   endgenerate

   // Round-robin pick: first pending channel at or above rr_q, wrapping.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            pick  = CHW'(idx);
         end
      end
   end

   // Arbiter next state, pending-slot update and drop flag.
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      pol_d    = pol_q;
      chan_d   = chan_q;
      rise_d   = rise_q;
      valid_d  = valid_q;
      rr_d     = rr_q;
      drop_d   = drop_q;
      clr_mask = '0;
      drop_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               chan_d         = pick;
               rise_d         = pol_q[pick];
               valid_d        = 1'b1;
               clr_mask[pick] = 1'b1;
               state_d        = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (valid_q && evt_ready_i) begin
               valid_d = 1'b0;
               rr_d    = (chan_q == CHAN_LAST) ? '0 : chan_q + CHW'(1);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      pend_d = pend_q & ~clr_mask;

      // A fresh qualified edge always lands in the slot; the newest polarity wins.
      for (int i = 0; i < N_CH; i++) begin
         if (post[i]) begin
            if (pend_q[i] && !clr_mask[i]) drop_set = 1'b1;
            pend_d[i] = 1'b1;
            pol_d[i]  = sync2_q[i];
         end
      end

      if (drop_clr_i) drop_d = 1'b0;
      if (drop_set)   drop_d = 1'b1;
   end

   // Arbiter and event-port registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         pol_q   <= '0;
         chan_q  <= '0;
         rise_q  <= 1'b0;
         valid_q <= 1'b0;
         rr_q    <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         pol_q   <= pol_d;
         chan_q  <= chan_d;
         rise_q  <= rise_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
         drop_q  <= drop_d;
      end
   end

   assign evt_valid_o = valid_q;
   assign evt_chan_o  = chan_q;
   assign evt_rise_o  = rise_q;
   assign evt_drop_o  = drop_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N_CH=4, TICK_DIV=4, STABLE_TICKS=3.
module tb_debounce_scheduler;

   logic       clk;
   logic       reset;
   logic [3:0] btn;
   logic [3:0] level;
   logic       valid;
   logic       ready;
   logic [1:0] chan;
   logic       rise;
   logic       drop;
   logic       drop_clr;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int valid_cnt = 0;
   int vc_mark;

   debounce_scheduler #(
      .N_CH(4),
      .TICK_DIV(4),
      .STABLE_TICKS(3)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .btn_in_i(btn),
      .btn_level_o(level),
      .evt_valid_o(valid),
      .evt_ready_i(ready),
      .evt_chan_o(chan),
      .evt_rise_o(rise),
      .evt_drop_o(drop),
      .drop_clr_i(drop_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count clock cycles on which an event is presented.
   always @(negedge clk) begin
      if (valid === 1'b1) valid_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance to absolute cycle 'target' counted from the last reset release; sample 1 ns after the edge.
   task automatic step_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic chk_evt(input string tag, input logic [1:0] ec, input logic er);
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_chan"},  32'(chan),  32'(ec));
      chk({tag, "_rise"},  32'(rise),  32'(er));
   endtask

   initial begin
      reset    = 1'b1;
      btn      = 4'b0000;
      ready    = 1'b1;
      drop_clr = 1'b0;
      do_reset();

      // Reset state
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_drop",  32'(drop),  32'd0);
      chk("rst_chan",  32'(chan),  32'd0);
      chk("rst_tickcnt", 32'(dut.tick_cnt_q), 32'd0);

      // 1. Tick every 4th clock, counter wraps 3 -> 0
      for (int c = 1; c <= 8; c++) begin
         step_to(c);
         chk("t1_tick",    32'(dut.tick),       (c % 4 == 3) ? 32'd1 : 32'd0);
         chk("t1_tickcnt", 32'(dut.tick_cnt_q), 32'(c % 4));
      end

      // 2. ch0 press: sync visible at 10, ticks 11/15/19, level at 20, event at 21
      btn[0] = 1'b1;
      step_to(19);
      chk("t2_level_pre", 32'(level[0]), 32'd0);
      step_to(20);
      chk("t2_level",     32'(level[0]), 32'd1);
      chk("t2_valid_pre", 32'(valid),    32'd0);
      step_to(21);
      chk_evt("t2_evt", 2'd0, 1'b1);
      step_to(22);
      chk("t2_valid_post", 32'(valid), 32'd0);

      // 3. ch1 glitch of two ticks is rejected
      step_to(24);
      vc_mark = valid_cnt;
      btn[1] = 1'b1;
      step_to(32);
      chk("t3_level_mid", 32'(level[1]), 32'd0);
      btn[1] = 1'b0;
      step_to(40);
      chk("t3_level", 32'(level[1]), 32'd0);
      chk("t3_noevt", 32'(valid_cnt), 32'(vc_mark));

      // 4. Simultaneous channels served in round-robin order
      btn = 4'b0000;
      do_reset();
      btn = 4'b1010;
      step_to(12);
      chk("t4_valid_pre", 32'(valid), 32'd0);
      step_to(13);
      chk_evt("t4_e1", 2'd1, 1'b1);
      step_to(14);
      chk("t4_gap1", 32'(valid), 32'd0);
      step_to(15);
      chk_evt("t4_e3", 2'd3, 1'b1);
      step_to(16);
      chk("t4_gap2", 32'(valid), 32'd0);
      btn = 4'b0000;
      step_to(29);
      chk_evt("t4_r1", 2'd1, 1'b0);
      step_to(31);
      chk_evt("t4_r3", 2'd3, 1'b0);
      step_to(32);
      btn = 4'b0011;
      step_to(45);
      chk_evt("t4_e0", 2'd0, 1'b1);
      step_to(46);
      chk("t4_gap3", 32'(valid), 32'd0);
      step_to(47);
      chk_evt("t4_e1b", 2'd1, 1'b1);

      // 5. Back-pressure: pending release then press on the presented channel -> drop
      btn   = 4'b0000;
      ready = 1'b0;
      do_reset();
      btn[2] = 1'b1;
      step_to(12);
      btn[2] = 1'b0;
      step_to(13);
      chk_evt("t5_press", 2'd2, 1'b1);
      step_to(23);
      chk("t5_level_hi", 32'(level[2]), 32'd1);
      step_to(24);
      chk("t5_level_lo", 32'(level[2]), 32'd0);
      chk("t5_nodrop",   32'(drop),     32'd0);
      chk_evt("t5_hold1", 2'd2, 1'b1);
      btn[2] = 1'b1;
      step_to(35);
      chk("t5_nodrop2", 32'(drop), 32'd0);
      step_to(36);
      chk("t5_drop", 32'(drop), 32'd1);
      chk_evt("t5_hold2", 2'd2, 1'b1);
      ready = 1'b1;
      step_to(37);
      chk("t5_gap", 32'(valid), 32'd0);
      step_to(38);
      chk_evt("t5_pend", 2'd2, 1'b1);
      step_to(39);
      chk("t5_valid_post", 32'(valid), 32'd0);
      chk("t5_drop_kept",  32'(drop),  32'd1);
      drop_clr = 1'b1;
      step_to(40);
      chk("t5_drop_clr", 32'(drop), 32'd0);
      drop_clr = 1'b0;

      // 6. Reset while presenting, then re-qualify the held button
      btn   = 4'b0000;
      ready = 1'b0;
      do_reset();
      btn[0] = 1'b1;
      step_to(13);
      chk_evt("t6_pre", 2'd0, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(valid), 32'd0);
      chk("t6_rst_level", 32'(level), 32'd0);
      chk("t6_rst_drop",  32'(drop),  32'd0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      cyc     = 0;
      ready   = 1'b1;
      vc_mark = valid_cnt;
      step_to(11);
      chk("t6_level_pre", 32'(level[0]), 32'd0);
      step_to(12);
      chk("t6_level",  32'(level[0]),  32'd1);
      chk("t6_noevt",  32'(valid_cnt), 32'(vc_mark));
      step_to(13);
      chk_evt("t6_evt", 2'd0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
